// File: rtl/fifo_chk_pkg.sv
// Definitions shared by the FIFO write-side pattern generator and read-side checker.
// Both ends must step the same LFSR so their sequences line up word for word.
package fifo_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } chk_state_t;

    localparam int LFSR_W = 40;

    // x^40 + x^38 + x^21 + x^19 + 1 -> state bits 39, 37, 20, 18
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 40'hA0_0014_0000;

    function automatic logic [LFSR_W-1:0] lfsr40_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
// One-cycle latency from inc to cnt; clr has priority over inc.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt,
    output logic         o_sat
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = &r_cnt;

endmodule

// File: rtl/fifo_rd_checker.sv
// Read-domain FIFO consumer: pops while started and data is present, checks words against the LFSR.
// Statistics update on the pop edge; o_rinc is the only combinational output and never pops an empty FIFO.
module fifo_rd_checker #(
    parameter int               DSIZE = 40,
    parameter int               CNT_W = 32,
    parameter logic [DSIZE-1:0] SEED  = 'h1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_resync,
    input  logic [3:0]       i_rd_gap,
    input  logic [CNT_W-1:0] i_num_words,
    input  logic             i_rempty_n,
    input  logic [DSIZE-1:0] i_rdata,
    output logic             o_rinc,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_rd_cnt,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_first_err_idx,
    output logic [DSIZE-1:0] o_first_err_data
);

    import fifo_chk_pkg::*;

    chk_state_t       r_state;
    chk_state_t       w_state_nxt;
    logic             r_start_q;
    logic [3:0]       r_gap_cnt;
    logic [DSIZE-1:0] r_expected;
    logic             r_done;
    logic [CNT_W-1:0] r_first_err_idx;
    logic [DSIZE-1:0] r_first_err_data;

    logic             w_start_rise;
    logic             w_run_clr;
    logic             w_pop;
    logic             w_mismatch;
    logic             w_err_inc;
    logic             w_hit_limit;
    logic [CNT_W-1:0] w_rd_cnt;
    logic [CNT_W-1:0] w_err_cnt;
    logic [CNT_W-1:0] w_rd_cnt_inc;
    logic             w_rd_sat;
    logic             w_err_sat;
    logic [DSIZE-1:0] w_exp_nxt;

    assign w_start_rise = i_start & ~r_start_q;
    assign w_run_clr    = (r_state == ST_IDLE) & w_start_rise;
    assign w_pop        = (r_state == ST_RUN) & i_start & i_rempty_n;
    assign w_mismatch   = (i_rdata != r_expected);
    assign w_err_inc    = w_pop & w_mismatch & ~w_err_sat;

    // Limit is compared against the post-pop count so a num_words already at or
    // below rd_cnt still terminates the run on the very next pop.
    assign w_rd_cnt_inc = w_rd_sat ? w_rd_cnt : w_rd_cnt + 1'b1;
    assign w_hit_limit  = (i_num_words != '0) && (w_rd_cnt_inc >= i_num_words);

    always_comb begin
        w_exp_nxt = lfsr40_next(r_expected);
        if (w_mismatch && i_resync) begin
            // an all-zero word would lock the LFSR, so restart the sequence instead
            w_exp_nxt = (i_rdata == '0) ? SEED : lfsr40_next(i_rdata);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_rise) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!i_start) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_pop) begin
                    if (w_hit_limit) w_state_nxt = ST_DONE;
                    else if (i_rd_gap != 4'd0) w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (!i_start) w_state_nxt = ST_IDLE;
                else if (r_gap_cnt <= 4'd1) w_state_nxt = ST_RUN;
            end
            ST_DONE: begin
                if (!i_start) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_start_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_q <= i_start;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gap_cnt <= 4'd0;
        end else if (w_run_clr) begin
            r_gap_cnt <= 4'd0;
        end else if (w_pop) begin
            r_gap_cnt <= i_rd_gap;
        end else if ((r_state == ST_GAP) && (r_gap_cnt != 4'd0)) begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_expected <= SEED;
        end else if (w_run_clr) begin
            r_expected <= SEED;
        end else if (w_pop) begin
            r_expected <= w_exp_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_done <= 1'b0;
        end else if (w_run_clr) begin
            r_done <= 1'b0;
        end else if (w_pop && w_hit_limit) begin
            r_done <= 1'b1;
        end
    end

    // err_cnt is zero exactly until the first mismatch of the run
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_first_err_idx  <= '1;
            r_first_err_data <= '0;
        end else if (w_run_clr) begin
            r_first_err_idx  <= '1;
            r_first_err_data <= '0;
        end else if (w_pop && w_mismatch && (w_err_cnt == '0)) begin
            r_first_err_idx  <= w_rd_cnt;
            r_first_err_data <= i_rdata;
        end
    end

    sat_counter #(.W(CNT_W)) u_rd_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (w_pop),
        .i_clr (w_run_clr),
        .o_cnt (w_rd_cnt),
        .o_sat (w_rd_sat)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (w_err_inc),
        .i_clr (w_run_clr),
        .o_cnt (w_err_cnt),
        .o_sat (w_err_sat)
    );

    assign o_rinc           = w_pop;
    assign o_busy           = (r_state == ST_RUN) || (r_state == ST_GAP);
    assign o_done           = r_done;
    assign o_rd_cnt         = w_rd_cnt;
    assign o_err_cnt        = w_err_cnt;
    assign o_first_err_idx  = r_first_err_idx;
    assign o_first_err_data = r_first_err_data;

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Directed bench for fifo_rd_checker: a show-ahead FIFO model feeds a 32-bit and a 4-bit counter instance.
module tb_fifo_rd_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start4, resync;
    logic [3:0]  rd_gap;
    logic [31:0] num_words;
    logic [3:0]  num_words4;
    logic        rempty_n = 1'b0;
    logic [39:0] rdata = 40'h0;

    logic        rinc, busy, done;
    logic [31:0] rd_cnt, err_cnt, fidx;
    logic [39:0] fdata;
    logic        rinc4, busy4, done4;
    logic [3:0]  rd_cnt4, err_cnt4, fidx4;
    logic [39:0] fdata4;

    always #5 clk = ~clk;

    fifo_rd_checker #(.DSIZE(40), .CNT_W(32), .SEED(40'h1)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_resync(resync), .i_rd_gap(rd_gap),
        .i_num_words(num_words), .i_rempty_n(rempty_n), .i_rdata(rdata),
        .o_rinc(rinc), .o_busy(busy), .o_done(done), .o_rd_cnt(rd_cnt), .o_err_cnt(err_cnt),
        .o_first_err_idx(fidx), .o_first_err_data(fdata)
    );

    fifo_rd_checker #(.DSIZE(40), .CNT_W(4), .SEED(40'h1)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start4), .i_resync(resync), .i_rd_gap(rd_gap),
        .i_num_words(num_words4), .i_rempty_n(rempty_n), .i_rdata(rdata),
        .o_rinc(rinc4), .o_busy(busy4), .o_done(done4), .o_rd_cnt(rd_cnt4), .o_err_cnt(err_cnt4),
        .o_first_err_idx(fidx4), .o_first_err_data(fdata4)
    );

    typedef struct {
        int          nfifo;
        int          corrupt_at;
        int          drop_at;
        bit          resync;
        int          nw;
        int          gap;
        int          exp_rd;
        int          exp_err;
        logic [31:0] exp_fidx;
        logic [39:0] exp_fdata;
        bit          exp_done;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [39:0] mem [0:1023];
    int          wr_ptr = 0, rd_ptr = 0, flush_ptr = 0;
    bit          allow = 1'b1;
    bit          rinc_q = 1'b0;
    bit          gap_mode = 1'b0;
    int          n_pops = 0, n_under = 0, n_gapv = 0, last_pop = -100, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rinc_q = rinc | rinc4;
        if (rinc | rinc4) begin
            n_pops++;
            if (!rempty_n) n_under++;
            if (gap_mode && (cyc - last_pop) < 4) n_gapv++;
            last_pop = cyc;
        end
    end

    // show-ahead FIFO: head word is presented whenever the FIFO is non-empty
    always begin
        @(posedge clk);
        if (rinc_q && rd_ptr < wr_ptr) rd_ptr++;
        #2;
        if (rd_ptr < flush_ptr) rd_ptr = flush_ptr;
        rempty_n = allow && (rd_ptr < wr_ptr);
        rdata    = (rd_ptr < wr_ptr) ? mem[rd_ptr] : 40'h0;
    end

    function automatic logic [39:0] tb_lfsr(input logic [39:0] s);
        logic fb;
        fb = s[39] ^ s[37] ^ s[20] ^ s[18];
        return {s[38:0], fb};
    endfunction

    function automatic logic [39:0] lfsr_word(input int k);
        logic [39:0] w;
        w = 40'h1;
        for (int i = 0; i < k; i++) w = tb_lfsr(w);
        return w;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [39:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic flush();
        flush_ptr = wr_ptr;
    endtask

    task automatic run_row(input int r, input vec_t v);
        start = 1'b0;
        tick(2);
        flush();
        for (int i = 0; i < v.nfifo; i++) begin
            int          src;
            logic [39:0] w;
            src = (v.drop_at >= 0 && i >= v.drop_at) ? i + 1 : i;
            w = lfsr_word(src);
            if (i == v.corrupt_at) w[0] = ~w[0];
            push(w);
        end
        rd_gap    = 4'(v.gap);
        resync    = v.resync;
        num_words = 32'(v.nw);
        tick(1);
        start = 1'b1;
        tick(v.nfifo * (v.gap + 1) + 8);
        chk($sformatf("row%0d_rd_cnt", r),    64'(rd_cnt),  64'(v.exp_rd));
        chk($sformatf("row%0d_err_cnt", r),   64'(err_cnt), 64'(v.exp_err));
        chk($sformatf("row%0d_first_idx", r), 64'(fidx),    64'(v.exp_fidx));
        chk($sformatf("row%0d_first_dat", r), 64'(fdata),   64'(v.exp_fdata));
        chk($sformatf("row%0d_done", r),      64'(done),    64'(v.exp_done));
        chk($sformatf("row%0d_busy", r),      64'(busy),    64'(!v.exp_done));
        start = 1'b0;
        tick(2);
        chk($sformatf("row%0d_idle_busy", r), 64'(busy),   64'(0));
        chk($sformatf("row%0d_held_rd", r),   64'(rd_cnt), 64'(v.exp_rd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vt [11];
        int   p0, u0, g0;

        vt[0]  = '{16, -1, -1, 1'b0, 16, 0, 16,  0, 32'hFFFF_FFFF, 40'h0,    1'b1};
        vt[1]  = '{16,  5, -1, 1'b0, 16, 0, 16,  1, 32'd5,         40'h21,   1'b1};
        vt[2]  = '{16,  5, -1, 1'b1, 16, 0, 16,  2, 32'd5,         40'h21,   1'b1};
        vt[3]  = '{16, -1,  5, 1'b1, 16, 0, 16,  1, 32'd5,         40'h40,   1'b1};
        vt[4]  = '{16, -1,  5, 1'b0, 16, 0, 16, 11, 32'd5,         40'h40,   1'b1};
        vt[5]  = '{60, -1, -1, 1'b0, 60, 0, 60,  0, 32'hFFFF_FFFF, 40'h0,    1'b1};
        vt[6]  = '{16, -1, -1, 1'b0, 10, 0, 10,  0, 32'hFFFF_FFFF, 40'h0,    1'b1};
        vt[7]  = '{12, -1, -1, 1'b0,  0, 0, 12,  0, 32'hFFFF_FFFF, 40'h0,    1'b0};
        vt[8]  = '{ 8, -1, -1, 1'b0,  8, 2,  8,  0, 32'hFFFF_FFFF, 40'h0,    1'b1};
        vt[9]  = '{16,  0, -1, 1'b0, 16, 0, 16,  1, 32'd0,         40'h0,    1'b1};
        vt[10] = '{16, 15, -1, 1'b0, 16, 0, 16,  1, 32'd15,        40'h8001, 1'b1};

        rst = 1'b1; start = 1'b0; start4 = 1'b0; resync = 1'b0;
        rd_gap = 4'd0; num_words = 32'd0; num_words4 = 4'd0;
        tick(2);
        chk("rst_rinc",      64'(rinc),  64'(0));
        chk("rst_busy",      64'(busy),  64'(0));
        chk("rst_done",      64'(done),  64'(0));
        chk("rst_rd_cnt",    64'(rd_cnt), 64'(0));
        chk("rst_err_cnt",   64'(err_cnt), 64'(0));
        chk("rst_first_idx", 64'(fidx),  64'hFFFF_FFFF);
        chk("rst_first_dat", 64'(fdata), 64'(0));
        chk("rst_first_idx4", 64'(fidx4), 64'hF);
        rst = 1'b0;
        tick(1);

        for (int r = 0; r < 11; r++) run_row(r, vt[r]);

        // reset asserted while popping back-to-back
        flush();
        for (int i = 0; i < 16; i++) push(lfsr_word(i));
        rd_gap = 4'd0; num_words = 32'd0; resync = 1'b0;
        tick(1);
        start = 1'b1;
        tick(4);
        chk("midrst_pre_rinc", 64'(rinc), 64'(1));
        rst = 1'b1;
        #1;
        chk("midrst_rinc",      64'(rinc),    64'(0));
        chk("midrst_busy",      64'(busy),    64'(0));
        chk("midrst_rd_cnt",    64'(rd_cnt),  64'(0));
        chk("midrst_first_idx", 64'(fidx),    64'hFFFF_FFFF);
        start = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);

        // drop start after exactly 7 pops, then restart from SEED
        flush();
        for (int i = 0; i < 16; i++) push(lfsr_word(i));
        tick(1);
        p0 = n_pops;
        start = 1'b1;
        for (int c = 0; c < 40 && (n_pops - p0) < 7; c++) tick(1);
        start = 1'b0;
        tick(2);
        chk("stop_pops",    64'(n_pops - p0), 64'(7));
        chk("stop_rd_cnt",  64'(rd_cnt),      64'(7));
        chk("stop_busy",    64'(busy),        64'(0));
        chk("stop_err_cnt", 64'(err_cnt),     64'(0));
        flush();
        for (int i = 0; i < 4; i++) push(lfsr_word(i));
        tick(1);
        start = 1'b1;
        tick(1);
        chk("restart_cleared", 64'(rd_cnt), 64'(0));
        tick(8);
        chk("restart_rd_cnt",  64'(rd_cnt),  64'(4));
        chk("restart_err_cnt", 64'(err_cnt), 64'(0));
        start = 1'b0;
        tick(2);

        // gap spacing with a randomly stalling FIFO
        flush();
        for (int i = 0; i < 20; i++) push(lfsr_word(i));
        rd_gap = 4'd3; num_words = 32'd0;
        gap_mode = 1'b1;
        p0 = n_pops; u0 = n_under; g0 = n_gapv;
        tick(1);
        start = 1'b1;
        for (int c = 0; c < 150; c++) begin
            allow = 1'($urandom_range(0, 1));
            tick(1);
        end
        start = 1'b0;
        allow = 1'b1;
        tick(2);
        gap_mode = 1'b0;
        chk("gap_rd_eq_pops",  64'(rd_cnt),        64'(n_pops - p0));
        chk("gap_some_pops",   64'(n_pops - p0 > 4), 64'(1));
        chk("gap_underflow",   64'(n_under - u0),  64'(0));
        chk("gap_spacing",     64'(n_gapv - g0),   64'(0));
        chk("gap_err_cnt",     64'(err_cnt),       64'(0));

        // num_words lowered below rd_cnt during a gap
        flush();
        for (int i = 0; i < 16; i++) push(lfsr_word(i));
        rd_gap = 4'd3; num_words = 32'd0;
        tick(1);
        start = 1'b1;
        for (int c = 0; c < 60 && rd_cnt != 32'd4; c++) tick(1);
        num_words = 32'd2;
        tick(20);
        chk("nwchg_rd_cnt", 64'(rd_cnt), 64'(5));
        chk("nwchg_done",   64'(done),   64'(1));
        chk("nwchg_busy",   64'(busy),   64'(0));
        start = 1'b0;
        tick(2);

        // 4-bit counters saturate while popping continues
        flush();
        for (int i = 0; i < 20; i++) push(lfsr_word(i) ^ 40'hFF);
        rd_gap = 4'd0; num_words4 = 4'd0; resync = 1'b0;
        tick(1);
        p0 = n_pops;
        start4 = 1'b1;
        tick(30);
        chk("sat_pops",      64'(n_pops - p0), 64'(20));
        chk("sat_rd_cnt",    64'(rd_cnt4),     64'hF);
        chk("sat_err_cnt",   64'(err_cnt4),    64'hF);
        chk("sat_first_idx", 64'(fidx4),       64'h0);
        chk("sat_first_dat", 64'(fdata4),      64'hFE);
        chk("sat_busy",      64'(busy4),       64'(1));
        start4 = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
